// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : alu_multicycle
// Brief    : Registered ALU. add/sub/and/or finish in one cycle, and mul is a
//            32-iteration shift-and-add.
// Revision : 1.0 - initial release
// ============================================================================
module alu_multicycle (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [2:0]  ALUCtrl_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    output logic [31:0] data_o,
    output logic        zero_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MUL  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [2:0] c_OP_AND = 3'b000;
    localparam logic [2:0] c_OP_OR  = 3'b001;
    localparam logic [2:0] c_OP_ADD = 3'b010;
    localparam logic [2:0] c_OP_SUB = 3'b110;
    localparam logic [2:0] c_OP_MUL = 3'b111;

    logic [1:0]  r_state;
    logic [31:0] r_data;
    logic        r_done;
    logic [31:0] r_acc;
    logic [31:0] r_mcand;
    logic [31:0] r_mplr;
    logic [4:0]  r_cnt;

    logic [31:0] w_alu;
    logic [31:0] w_acc_next;

    // Unsupported opcodes fall through to zero.
    always_comb begin
        w_alu = 32'd0;
        case (ALUCtrl_i)
            c_OP_ADD: w_alu = data1_i + data2_i;
            c_OP_SUB: w_alu = data1_i - data2_i;
            c_OP_AND: w_alu = data1_i & data2_i;
            c_OP_OR:  w_alu = data1_i | data2_i;
            default:  w_alu = 32'd0;
        endcase
    end

    assign w_acc_next = r_mplr[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
            r_data  <= 32'd0;
            r_done  <= 1'b0;
            r_acc   <= 32'd0;
            r_mcand <= 32'd0;
            r_mplr  <= 32'd0;
            r_cnt   <= 5'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_done <= 1'b0;
                    if (start_i) begin
                        r_mcand <= data1_i;
                        r_mplr  <= data2_i;
                        r_acc   <= 32'd0;
                        r_cnt   <= 5'd0;
                        if (ALUCtrl_i == c_OP_MUL) begin
                            r_state <= c_MUL;
                        end else begin
                            r_data  <= w_alu;
                            r_done  <= 1'b1;
                            r_state <= c_DONE;
                        end
                    end
                end
                c_MUL: begin
                    r_acc   <= w_acc_next;
                    r_mcand <= r_mcand << 1;
                    r_mplr  <= r_mplr >> 1;
                    r_cnt   <= r_cnt + 5'd1;
                    // The final iteration's sum goes straight to the result.
                    if (r_cnt == 5'd31) begin
                        r_data  <= w_acc_next;
                        r_done  <= 1'b1;
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign data_o = r_data;
    assign zero_o = (r_data == 32'd0);
    assign busy_o = (r_state != c_IDLE);
    assign done_o = r_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_multicycle
// Brief    : Directed self-checking bench for alu_multicycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_multicycle;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  ctrl;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] data_o;
    logic        zero_o;
    logic        busy_o;
    logic        done_o;

    int          n_checks;
    int          n_pass;
    logic [31:0] last_result;

    alu_multicycle dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .ALUCtrl_i (ctrl),
        .data1_i   (data1),
        .data2_i   (data2),
        .data_o    (data_o),
        .zero_o    (zero_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Single-cycle op: done one cycle after the accepting edge, then idle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input logic [31:0] exp, input string tag);
        start = 1'b1; data1 = a; data2 = b; ctrl = op;
        @(posedge clk); #1;
        start = 1'b0; data1 = ~a; data2 = ~b;
        check({tag, "_done"}, {31'd0, done_o}, 32'd1);
        check({tag, "_data"}, data_o, exp);
        check({tag, "_zero"}, {31'd0, zero_o}, {31'd0, exp == 32'd0});
        check({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
        @(posedge clk); #1;
        check({tag, "_done_clr"}, {31'd0, done_o}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_hold"}, data_o, exp);
        last_result = exp;
    endtask

    // Multiply with latency/busy/hold checks; optional start pulse while busy.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input string tag, input int inject_at);
        int   cyc;
        int   busy_cnt;
        int   extra_done;
        logic held;
        busy_cnt = 0; held = 1'b1; extra_done = 0;
        start = 1'b1; data1 = a; data2 = b; ctrl = 3'b111;
        @(posedge clk); #1;
        start = 1'b0; data1 = 32'h0000_0001; data2 = 32'h0000_0002; ctrl = 3'b010;
        cyc = 1;
        while (!done_o && cyc < 40) begin
            if (busy_o) busy_cnt++;
            if (data_o !== last_result) held = 1'b0;
            start = (cyc == inject_at);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (busy_o) busy_cnt++;
        check({tag, "_latency"}, 32'(cyc), 32'd33);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
        check({tag, "_no_intermediate"}, {31'd0, held}, 32'd1);
        check({tag, "_data"}, data_o, exp);
        check({tag, "_zero"}, {31'd0, zero_o}, {31'd0, exp == 32'd0});
        last_result = exp;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done_o) extra_done++;
        end
        check({tag, "_single_done"}, 32'(extra_done), 32'd0);
        check({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_hold"}, data_o, exp);
    endtask

    initial begin
        int cyc;
        int stray_done;
        n_checks = 0; n_pass = 0; last_result = 32'd0;
        rst = 1'b1; start = 1'b0; ctrl = 3'b000; data1 = 32'd0; data2 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", data_o, 32'd0);
        check("rst_zero", {31'd0, zero_o}, 32'd1);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        rst = 1'b0;

        // First start right after reset release, then back-to-back ops.
        run_op(32'h0000_0005, 32'h0000_0007, 3'b010, 32'h0000_000C, "add");
        run_op(32'h1234_5678, 32'h1234_5678, 3'b110, 32'h0000_0000, "sub_zero");
        run_op(32'h0000_0000, 32'h0000_0001, 3'b110, 32'hFFFF_FFFF, "sub_wrap");
        run_op(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 32'hF000_F000, "and");
        run_op(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b001, 32'hFFF0_FFF0, "or");
        run_op(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b011, 32'h0000_0000, "unsup");
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 32'h0000_0000, "add_wrap");

        run_mul(32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, "mul_neg", 5);
        run_mul(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, "mul_ovf", 0);
        run_mul(32'h1234_5678, 32'h0000_0010, 32'h2345_6780, "mul_shift", 0);

        // Abort a multiply after 10 iterations; a coincident start is ignored.
        start = 1'b1; data1 = 32'hFFFF_FFFF; data2 = 32'h0000_0003; ctrl = 3'b111;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (cyc < 9) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("abort_busy_before", {31'd0, busy_o}, 32'd1);
        rst = 1'b1; start = 1'b1; data1 = 32'd1; data2 = 32'd1; ctrl = 3'b010;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        check("abort_data", data_o, 32'd0);
        check("abort_zero", {31'd0, zero_o}, 32'd1);
        check("abort_done", {31'd0, done_o}, 32'd0);
        stray_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done_o || busy_o) stray_done++;
        end
        check("abort_quiet", 32'(stray_done), 32'd0);
        last_result = 32'd0;
        run_op(32'h0000_0005, 32'h0000_0007, 3'b010, 32'h0000_000C, "add_after_abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have one clock and synchronous active-high reset; all state changes on rising edge of clk_i only.
REQ-002 SHALL provide the following ports:
  clk_i        in   1   system clock
  rst_i        in   1   synchronous reset, active-high
  start_i      in   1   operation request, sampled only in IDLE
  ALUCtrl_i    in   3   operation code from ALU control decoder
  data1_i      in   32  operand A (rs)
  data2_i      in   32  operand B (rt)
  data_o       out  32  registered result
  zero_o       out  1   high when data_o == 0
  busy_o       out  1   high whenever state != IDLE
  done_o       out  1   one-cycle completion pulse
REQ-003 SHALL decode ALUCtrl_i as: 010 add, 110 sub, 000 and, 001 or, 111 mul; all other codes are "unsupported".

Function
REQ-004 SHALL implement states IDLE, MUL, DONE.
REQ-005 SHALL, in IDLE with start_i=1, latch data1_i, data2_i and ALUCtrl_i into internal registers; later changes of the inputs SHALL NOT affect the operation in flight.
REQ-006 SHALL, for add/sub/and/or/unsupported, compute the result at the accepting edge, load it into data_o and enter DONE.
  - add: A+B mod 2^32; sub: A-B mod 2^32 (two's complement, no overflow flag).
  - and/or: bitwise.
  - unsupported: result 0.
REQ-007 SHALL, for mul, enter MUL with accumulator=0, multiplicand=A, multiplier=B, iteration counter=0.
REQ-008 SHALL, per MUL cycle:
  - if multiplier[0]=1, add multiplicand to accumulator;
  - shift multiplicand left 1 and multiplier right 1 (both logical);
  - increment counter.
REQ-009 SHALL leave MUL after exactly 32 iterations (counter 31 -> exit), loading the low 32 bits of A*B (unsigned, equal to signed low word) into data_o and entering DONE.
REQ-010 SHALL assert done_o for exactly one cycle, only while in DONE, then return to IDLE on the next edge.
REQ-011 Latency SHALL be fixed, counting from the edge that samples start_i=1:
  - single-cycle ops: done_o high in the following cycle (1 cycle);
  - mul: done_o high 33 cycles later.
REQ-012 SHALL ignore start_i while in MUL or DONE; no request queuing.
REQ-013 SHALL accept a new start in the cycle after DONE, giving back-to-back throughput of one op per 2 cycles for single-cycle ops.
REQ-014 SHALL hold data_o (and so zero_o) unchanged except at the edge entering DONE; data_o SHALL NOT show intermediate accumulator values.
REQ-015 zero_o SHALL be combinational from data_o (no extra latency).
REQ-016 busy_o SHALL be high in MUL and DONE, and low in IDLE.

Reset
REQ-017 rst_i=1 at an edge SHALL force state=IDLE, data_o=0, done_o=0, busy_o=0, and clear the accumulator, counter and latched operands; zero_o therefore reads 1.
REQ-018 Reset in MUL or DONE SHALL abort the operation with no done_o pulse; a start_i coincident with rst_i SHALL be ignored.
REQ-019 After reset deassertion, the first start_i SHALL be accepted at the first edge with rst_i=0.

Verification
REQ-020 Directed scenarios the bench SHALL cover:
  - add: A=0x00000005, B=0x00000007, ctrl=010 -> next cycle done_o=1, data_o=0x0000000C, zero_o=0.
  - sub to zero: A=B=0x12345678, ctrl=110 -> data_o=0, zero_o=1; also A=0, B=1 -> data_o=0xFFFFFFFF.
  - and/or/unsupported: A=0xF0F0F0F0, B=0xFF00FF00:
      and -> 0xF000F000;
      or -> 0xFFF0FFF0;
      ctrl=011 -> 0x00000000.
  - mul: A=0xFFFFFFFF (-1), B=0x00000003, ctrl=111 -> busy_o high 33 cycles, done_o at start+33, data_o=0xFFFFFFFD; also A=0x00010000, B=0x00010000 -> data_o=0.
  - start while busy: during mul, pulse start_i with ctrl=010 -> ignored; only one done_o, with the mul result.
  - reset mid-mul: assert rst_i at iteration 10 -> next cycle busy_o=0, data_o=0, no done_o; a new add then completes normally in 1 cycle.
